// File: rtl/vec_elem_sequencer_if.sv
// Issue / retire / memory-handshake bundle between the execute-stage
// front end and the vector element sequencer.
interface vec_elem_sequencer_if #(
    parameter int LANES = 4
);
    localparam int IDXW = $clog2(LANES);

    logic            issue_valid;
    logic [3:0]      opcode;
    logic [IDXW:0]   vlen;
    logic            flush;
    logic            mem_ack;
    logic            issue_ready;
    logic            stall;
    logic [IDXW-1:0] elem_idx;
    logic            elem_en;
    logic            mem_req;
    logic            mem_we;
    logic            done;

    modport master (
        output issue_valid, opcode, vlen, flush, mem_ack,
        input  issue_ready, stall, elem_idx, elem_en, mem_req, mem_we, done
    );

    modport slave (
        input  issue_valid, opcode, vlen, flush, mem_ack,
        output issue_ready, stall, elem_idx, elem_en, mem_req, mem_we, done
    );
endinterface

// File: rtl/vec_elem_sequencer.sv
// Steps one vector instruction through its elements, counting out multi-cycle
// ALU latency or waiting on memory acks, and stalls the front end meanwhile.
module vec_elem_sequencer #(
    parameter int LANES   = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input logic                clk,
    input logic                rst_n,
    vec_elem_sequencer_if.slave bus
);
    localparam int IDXW   = $clog2(LANES);
    localparam int LATMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNTW   = (LATMAX > 1) ? $clog2(LATMAX) : 1;

    typedef enum logic [1:0] {IDLE, RUN, MEM, FIN} state_t;

    state_t          state, state_d;
    logic [3:0]      op_q, op_d;
    logic [IDXW:0]   len_q, len_d;
    logic [IDXW-1:0] idx, idx_d;
    logic [CNTW-1:0] cnt, cnt_d;

    logic issue_ready, elem_en, mem_req, mem_we, done;
    logic [IDXW:0] len_in;
    logic          last;

    // Per-element cycle count minus one; only multi-cycle ALU ops are nonzero.
    function automatic logic [CNTW-1:0] lat_m1(input logic [3:0] op);
        case (op)
            4'b0000: lat_m1 = CNTW'(MUL_LAT - 1);
            4'b0001: lat_m1 = CNTW'(DIV_LAT - 1);
            default: lat_m1 = '0;
        endcase
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        is_alu = (op == 4'b0100) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        is_mem = (op == 4'b0010) || (op == 4'b0011);
    endfunction

    assign len_in = (bus.vlen > (IDXW+1)'(LANES)) ? (IDXW+1)'(LANES) : bus.vlen;
    assign last   = ({1'b0, idx} == (len_q - (IDXW+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            len_q <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            op_q  <= op_d;
            len_q <= len_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        len_d       = len_q;
        idx_d       = idx;
        cnt_d       = cnt;
        issue_ready = 1'b0;
        elem_en     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = !bus.flush;
                if (bus.issue_valid && !bus.flush) begin
                    op_d  = bus.opcode;
                    len_d = len_in;
                    idx_d = '0;
                    cnt_d = lat_m1(bus.opcode);
                    if (len_in == '0 || !(is_alu(bus.opcode) || is_mem(bus.opcode)))
                        state_d = FIN;
                    else if (is_mem(bus.opcode))
                        state_d = MEM;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNTW'(1);
                end else begin
                    elem_en = 1'b1;
                    cnt_d   = lat_m1(op_q);
                    if (last) state_d = FIN;
                    else      idx_d   = idx + IDXW'(1);
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == 4'b0011);
                if (bus.mem_ack) begin
                    elem_en = 1'b1;
                    if (last) state_d = FIN;
                    else      idx_d   = idx + IDXW'(1);
                end
            end
            FIN: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Branch-taken cancel wins over everything, including a same-cycle issue.
        if (bus.flush) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            elem_en = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            done    = 1'b0;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.stall       = (state != IDLE) || (bus.issue_valid && issue_ready);
    assign bus.elem_idx    = idx;
    assign bus.elem_en     = elem_en;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.done        = done;
endmodule

// File: doc/vec_elem_sequencer.md
# vec_elem_sequencer

Element-level sequencer for vector instructions in the ASIP execute stage. It accepts one decoded vector instruction at a time and steps the shared scalar ALU and data-memory port through the instruction's elements. It emits a per-element write enable and element index, and holds the front of the pipeline stalled until the last element retires. Multi-cycle ALU ops (mult, div) and handshaked memory ops (load, store) are counted or waited out here, so the ALU and memory stay free of control state.

## Interface
- LANES, 4: max elements per vector; power of two, ≥2
- MUL_LAT, 2: cycles per mult element; ≥1
- DIV_LAT, 8: cycles per div element; ≥1
- IDXW, $clog2(LANES): element index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decoded instruction present
- opcode  in  4  same encoding as the decoder
- vlen  in  IDXW+1  element count, 0..LANES; values >LANES are clamped to LANES
- flush  in  1  synchronous cancel (branch taken)
- mem_ack  in  1  memory completes current element
- issue_ready  out  1  sequencer can accept
- stall  out  1  hold fetch/decode
- elem_idx  out  IDXW  current element
- elem_en  out  1  retire current element (regfile/memory write strobe)
- mem_req  out  1  memory access request
- mem_we  out  1  store qualifier, valid with mem_req
- done  out  1  one-cycle pulse, instruction complete

## Operation
- States: IDLE, RUN, MEM, FIN.
- Opcode classes:
  - 0100 add and 0110 addi: latency 1.
  - 0000 mult: latency MUL_LAT.
  - 0001 div: latency DIV_LAT.
  - 0010 load and 0011 store: memory class.
  - All other opcodes, including 1000 and 1001 branches, are scalar.
- IDLE: issue_ready=1 when flush=0. On issue_valid&&issue_ready, latch opcode and vlen, set idx=0 and cnt=latency-1.
  - Scalar opcode or vlen==0: go to FIN.
  - Memory class: go to MEM.
  - Otherwise: go to RUN.
- RUN: elem_en=(cnt==0). If cnt≠0, decrement. At cnt==0:
  - If idx==vlen-1, go to FIN.
  - Otherwise idx++ and reload cnt.
- MEM: mem_req=1; mem_we=1 for store (0011), 0 for load. elem_en=mem_ack. On mem_ack, advance idx or go to FIN as in RUN. mem_req stays high through back-to-back elements.
- FIN: done=1 for one cycle, then go to IDLE.
- stall = (state≠IDLE) || (issue_valid&&issue_ready).
- elem_idx = idx, and is held stable while an element is in progress.
- flush has priority in every state:
  - Next state is IDLE.
  - elem_en, mem_req and done are forced to 0 in the flush cycle.
  - idx and cnt are cleared.
  - An issue in the same cycle is not accepted.
- mem_ack outside MEM is ignored.
- Reset values: state IDLE, idx=0, cnt=0. Outputs: issue_ready=1, stall=0, elem_en=0, mem_req=0, mem_we=0, done=0, elem_idx=0.

## Timing
- Issue accepted at edge 0 (the cycle in which issue_valid&&issue_ready).
- Latency-L ALU op with vlen=N: elem_en high in cycles k·L for k=1..N, counted after acceptance. done is high in cycle N·L+1. issue_ready returns in cycle N·L+2.
- Memory op: elem_en coincides with each mem_ack cycle. done is high the cycle after the last ack.
- Scalar opcode or vlen=0: done is high in cycle 1, with no elem_en or mem_req.
- elem_en, mem_req, mem_we and done are combinational from state/cnt/mem_ack/flush. There is no combinational path from issue_valid to elem_en.
- Asynchronous reset mid-instruction drops all outputs immediately. No done is produced for the aborted instruction.

## Test plan
- Add: opcode 0100, vlen=4 -> elem_en in cycles 1–4 with elem_idx 0,1,2,3; done in cycle 5; issue_ready=1 in cycle 6; stall high in cycles 0–5.
- Div: opcode 0001, vlen=2, DIV_LAT=8 -> elem_en only in cycles 8 and 16 (idx 0 then 1); done in cycle 17.
- Store: opcode 0011, vlen=3, mem_ack delayed 0/2/1 extra cycles -> mem_req and mem_we high continuously; exactly 3 elem_en pulses aligned with the acks; done the cycle after the third ack.
- Flush: flush in cycle 3 of a vlen=4 add -> no elem_en in cycle 3; no done; issue_ready=1 in cycle 4. A second issue_valid held during the flush cycle is accepted in cycle 4.
- Edge cases: opcode 1001 -> done in cycle 1 with no elem_en. vlen=0 add -> same. vlen=7 with LANES=4 -> exactly 4 elements.
- Reset: rst_n low while in MEM -> mem_req, stall and elem_en drop without waiting for a clock. After release: state IDLE, elem_idx=0; a stray mem_ack produces no elem_en.
